// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types: RAM handshake state and responder FSM states.
// Also holds the saturating-increment helpers used by the perf counters.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } memresp_state_t;

  function automatic logic [31:0] sat_inc32(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/memory_responder_timer.sv
// access_timer: counts non-ACCESS cycles of one RAM access.
// expired is high while the count sits at TIMEOUT-1.
module access_timer
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT) + 1;

  logic [W-1:0] r_cnt;

  assign expired = (r_cnt == W'(TIMEOUT - 1));

  // Wait counter; holds at the limit until the FSM leaves the access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_cnt <= '0;
    else if (clear)
      r_cnt <= '0;
    else if (enable && !expired)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/memory_responder.sv
// memory_responder: serialises data/instruction requests onto one RAM port.
// Optional MEMORY_RESPONDER_PERF_EN adds hit/error counters (icount/dcount/ecount).
module memory_responder
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              ihit,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dhit,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              merr
`ifdef MEMORY_RESPONDER_PERF_EN
  ,
  output logic [31:0]       icount,
  output logic [31:0]       dcount,
  output logic [15:0]       ecount
`endif
);

  memresp_state_t r_state;
  memresp_state_t w_next;
  logic           w_expired;
  logic           w_clear;
  logic           w_enable;

  assign w_clear  = (r_state == IDLE);
  assign w_enable = (ramstate != ACCESS);

  access_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .nRST   (nRST),
    .clear  (w_clear),
    .enable (w_enable),
    .expired(w_expired)
  );

  // State register; every access returns to IDLE before the next.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next state and all outputs; withdrawal beats completion and errors.
  always_comb begin
    w_next   = r_state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    merr     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (dREN || dWEN)
          w_next = DACC;
        else if (iREN)
          w_next = IACC;
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!(dREN || dWEN)) begin
          w_next = IDLE;
        end else if (ramstate == ACCESS) begin
          dhit   = 1'b1;
          dload  = ramload;
          w_next = IDLE;
        end else if (ramstate == ERROR || w_expired) begin
          merr   = 1'b1;
          w_next = IDLE;
        end
      end
      IACC: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        if (!iREN) begin
          w_next = IDLE;
        end else if (ramstate == ACCESS) begin
          ihit   = 1'b1;
          iload  = ramload;
          w_next = IDLE;
        end else if (ramstate == ERROR || w_expired) begin
          merr   = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef MEMORY_RESPONDER_PERF_EN
  logic [31:0] r_icount;
  logic [31:0] r_dcount;
  logic [15:0] r_ecount;

  assign icount = r_icount;
  assign dcount = r_dcount;
  assign ecount = r_ecount;

  // Saturating event counters for hits and aborted accesses.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_icount <= '0;
      r_dcount <= '0;
      r_ecount <= '0;
    end else begin
      if (ihit) r_icount <= sat_inc32(r_icount);
      if (dhit) r_dcount <= sat_inc32(r_dcount);
      if (merr) r_ecount <= sat_inc16(r_ecount);
    end
  end
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: per-cycle model compare plus directed literals.
// Build with MEMORY_RESPONDER_PERF_EN to also exercise the counters.
module tb_memory_responder;
  import cpu_types_pkg::*;

  localparam int TO = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, merr;
  ramstate_t   ramstate;
`ifdef MEMORY_RESPONDER_PERF_EN
  logic [31:0] icount, dcount;
  logic [15:0] ecount;
`endif

  memory_responder #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iload   (iload),
    .ihit    (ihit),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dload   (dload),
    .dhit    (dhit),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .merr    (merr)
`ifdef MEMORY_RESPONDER_PERF_EN
    ,
    .icount  (icount),
    .dcount  (dcount),
    .ecount  (ecount)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: who is being served (0 none, 1 data, 2 fetch), cycles waited.
  int          m_srv, m_wait, n_srv, n_wait;
  longint      m_ic, m_dc, m_ec, n_ic, n_dc, n_ec;

  initial begin
    m_srv = 0; m_wait = 0; n_srv = 0; n_wait = 0;
    m_ic = 0; m_dc = 0; m_ec = 0; n_ic = 0; n_dc = 0; n_ec = 0;
  end

  always @(negedge CLK) begin
    logic        e_ih, e_dh, e_re, e_we, e_me, done;
    logic [31:0] e_il, e_dl, e_ad, e_st;
    e_ih = 0; e_dh = 0; e_re = 0; e_we = 0; e_me = 0;
    e_il = 0; e_dl = 0; e_ad = 0; e_st = 0; done = 0;
    if (!nRST) begin
      m_srv = 0; m_wait = 0; m_ic = 0; m_dc = 0; m_ec = 0;
    end
    n_srv = m_srv; n_wait = m_wait + 1;
    if (m_srv == 0) begin
      n_wait = 0;
      if (dREN || dWEN) n_srv = 1;
      else if (iREN) n_srv = 2;
    end else begin
      if (m_srv == 1) begin
        e_ad = daddr; e_st = dstore;
        e_we = dWEN; e_re = dREN && !dWEN;
        done = !(dREN || dWEN);
      end else begin
        e_ad = iaddr; e_re = iREN;
        done = !iREN;
      end
      if (!done && ramstate == ACCESS) begin
        if (m_srv == 1) begin e_dh = 1; e_dl = ramload; end
        else begin e_ih = 1; e_il = ramload; end
        done = 1;
      end else if (!done && (ramstate == ERROR || m_wait == TO - 1)) begin
        e_me = 1; done = 1;
      end
      if (done) n_srv = 0;
    end
    if (!nRST) begin
      n_srv = 0; n_wait = 0;
    end
    n_ic = m_ic + e_ih; n_dc = m_dc + e_dh; n_ec = m_ec + e_me;
    cmp("ihit", 32'(ihit), 32'(e_ih));
    cmp("iload", iload, e_il);
    cmp("dhit", 32'(dhit), 32'(e_dh));
    cmp("dload", dload, e_dl);
    cmp("ramREN", 32'(ramREN), 32'(e_re));
    cmp("ramWEN", 32'(ramWEN), 32'(e_we));
    cmp("ramaddr", ramaddr, e_ad);
    cmp("ramstore", ramstore, e_st);
    cmp("merr", 32'(merr), 32'(e_me));
`ifdef MEMORY_RESPONDER_PERF_EN
    cmp("icount", icount, 32'(m_ic));
    cmp("dcount", dcount, 32'(m_dc));
    cmp("ecount", 32'(ecount), 32'(m_ec));
`endif
  end

  always @(posedge CLK) begin
    if (nRST) begin
      m_srv  <= n_srv;
      m_wait <= n_wait;
      m_ic   <= n_ic;
      m_dc   <= n_dc;
      m_ec   <= n_ec;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    nRST = 0; iREN = 1; dREN = 0; dWEN = 0;
    iaddr = 32'h0000_0010; daddr = 0; dstore = 0;
    ramload = 32'hCAFE_0001; ramstate = ACCESS;
    repeat (2) @(posedge CLK);
    #2;
    cmp("rst_ihit", 32'(ihit), 32'd0);
    cmp("rst_ramREN", 32'(ramREN), 32'd0);
    cmp("rst_iload", iload, 32'd0);
    nRST = 1;
    step();
    settle();
    cmp("t1_ihit", 32'(ihit), 32'd1);
    cmp("t1_iload", iload, 32'hCAFE_0001);
    iREN = 0;
    step();

    dREN = 1; daddr = 32'h100; ramstate = BUSY; ramload = 32'hDEAD_BEEF;
    settle();
    cmp("t2_idle_ren", 32'(ramREN), 32'd0);
    step();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) ramstate = ACCESS;
      settle();
      cmp("t2_ramREN", 32'(ramREN), 32'd1);
      cmp("t2_ramaddr", ramaddr, 32'h100);
      cmp("t2_dhit", 32'(dhit), (k == 4) ? 32'd1 : 32'd0);
      if (k == 4) cmp("t2_dload", dload, 32'hDEAD_BEEF);
      step();
    end
    dREN = 0;
    settle();
    cmp("t2_after", 32'(ramREN), 32'd0);

    dREN = 1; dWEN = 1; iREN = 1; daddr = 32'h40; dstore = 32'h1234;
    iaddr = 32'h200; ramload = 32'h5555_AAAA; ramstate = ACCESS;
    step();
    settle();
    cmp("t3_wen", 32'(ramWEN), 32'd1);
    cmp("t3_ren", 32'(ramREN), 32'd0);
    cmp("t3_addr", ramaddr, 32'h40);
    cmp("t3_store", ramstore, 32'h1234);
    cmp("t3_dhit", 32'(dhit), 32'd1);
    step();
    dREN = 0; dWEN = 0;
    step();
    settle();
    cmp("t3_iaddr", ramaddr, 32'h200);
    cmp("t3_ihit", 32'(ihit), 32'd1);
    cmp("t3_iload", iload, 32'h5555_AAAA);
    step();

    ramstate = BUSY;
    step();
    for (int k = 1; k <= TO; k++) begin
      settle();
      cmp("t4_merr", 32'(merr), (k == TO) ? 32'd1 : 32'd0);
      cmp("t4_ihit", 32'(ihit), 32'd0);
      step();
    end
    settle();
    cmp("t4_idle", 32'(ramREN), 32'd0);
    step();
    settle();
    cmp("t4_reenter", 32'(ramREN), 32'd1);
    iREN = 0;
    step();

    dREN = 1; ramstate = BUSY;
    step();
    step();
    ramstate = ERROR;
    settle();
    cmp("t5_merr", 32'(merr), 32'd1);
    cmp("t5_dhit", 32'(dhit), 32'd0);
    step();
    ramstate = BUSY;
    settle();
    cmp("t5_idle", 32'(ramREN), 32'd0);
    step();
    step();
    dREN = 0;
    settle();
    cmp("t5_wd_merr", 32'(merr), 32'd0);
    cmp("t5_wd_dhit", 32'(dhit), 32'd0);
    step();

    dREN = 1;
    step();
    settle();
    cmp("t5_rst_pre", 32'(ramREN), 32'd1);
    nRST = 0;
    settle();
    cmp("t5_rst_ren", 32'(ramREN), 32'd0);
    cmp("t5_rst_addr", ramaddr, 32'd0);
    dREN = 0;
    step();
    nRST = 1;
    step();

`ifdef MEMORY_RESPONDER_PERF_EN
    nRST = 0;
    step();
    nRST = 1;
    iREN = 1; ramstate = ACCESS;
    repeat (10) step();
    iREN = 0; dREN = 1;
    repeat (6) step();
    dREN = 0; iREN = 1; ramstate = BUSY;
    repeat (17) step();
    iREN = 0;
    step();
    cmp("t6_icount", icount, 32'd5);
    cmp("t6_dcount", dcount, 32'd3);
    cmp("t6_ecount", 32'(ecount), 32'd1);
    nRST = 0;
    settle();
    cmp("t6_clr_i", icount, 32'd0);
    cmp("t6_clr_d", dcount, 32'd0);
    cmp("t6_clr_e", 32'(ecount), 32'd0);
    step();
    nRST = 1;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
